// File: rtl/noc_bridge_narrow_wide_pkg.sv
// Shared types and constants for the narrow/wide NoC <-> AXIS bridge.
// Channel header encoding, strobe patterns, flit/AXIS structs and the RX FSM states.
package noc_bridge_narrow_wide_pkg;

  localparam int NarrowFlitDataSize = 64;
  localparam int WideFlitDataSize   = 128;
  localparam int HdrWidth           = 2;
  localparam int AxisDataWidth      = WideFlitDataSize + HdrWidth;
  localparam int AxisStrbWidth      = WideFlitDataSize / 8;

  localparam logic [AxisStrbWidth-1:0] NarrowStrobe =
    {{(AxisStrbWidth - NarrowFlitDataSize / 8){1'b0}}, {(NarrowFlitDataSize / 8){1'b1}}};
  localparam logic [AxisStrbWidth-1:0] WideStrobe = '1;

  // Encoding 2'd3 is unused on the link and marks a malformed beat.
  typedef enum logic [1:0] {
    narrow_request  = 2'd0,
    narrow_response = 2'd1,
    wide_channel    = 2'd2
  } channel_hdr_e;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ACTIVE   = 2'd1,
    DRAINING = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [AxisDataWidth-1:0] data;
    logic [AxisStrbWidth-1:0] strb;
    logic                     last;
  } axis_t_chan_t;

  typedef struct packed {
    logic         tvalid;
    axis_t_chan_t t;
  } axis_req_t;

  typedef struct packed {
    logic tready;
  } axis_rsp_t;

  typedef struct packed {
    logic                          valid;
    logic                          ready;
    logic [NarrowFlitDataSize-1:0] data;
  } narrow_req_flit_t;

  typedef struct packed {
    logic                          valid;
    logic                          ready;
    logic [NarrowFlitDataSize-1:0] data;
  } narrow_rsp_flit_t;

  typedef struct packed {
    logic                        valid;
    logic                        ready;
    logic [WideFlitDataSize-1:0] data;
  } wide_flit_t;

  function automatic logic beat_malformed(input logic [HdrWidth-1:0] hdr,
                                          input logic [AxisStrbWidth-1:0] strb);
    logic bad;
    bad = 1'b1;
    case (hdr)
      narrow_request, narrow_response: bad = (strb != NarrowStrobe);
      wide_channel:                    bad = (strb != WideStrobe);
      default:                         bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/floo_axis_rx_chan_buf.sv
// Per-channel receive FIFO: registered output (no fall-through, no bypass),
// valid/ready pop side and an optional one-cycle credit pulse per pop (FLOO_AXIS_RX_CREDIT_EN).
module floo_axis_rx_chan_buf #(
  parameter int unsigned Width        = 64,
  parameter int unsigned Depth        = 4,
  parameter bit          IgnoreAssert = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             credit_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign valid_o = !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // A full buffer refuses pushes even when it is being popped in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

`ifdef FLOO_AXIS_RX_CREDIT_EN
  assign credit_o = pop_ok;
`else
  assign credit_o = 1'b0;
`endif

  if (!IgnoreAssert) begin : gen_asserts
    a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && full_o));
    a_stable_out : assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_o && !ready_i) |=> (valid_o && $stable(data_o)));
  end

endmodule

// File: rtl/floo_axis_noc_rx_demux.sv
// Receive demux: decodes the channel header of each AXIS beat and steers it into one of
// three independent channel buffers. Optional credit pulses via FLOO_AXIS_RX_CREDIT_EN.
//
// Handshake: a transfer happens on every rising clk_i where valid and ready are both high;
// a valid output holds its data until accepted. tready may depend on the beat's header.
module floo_axis_noc_rx_demux
  import noc_bridge_narrow_wide_pkg::*;
#(
  parameter int unsigned FifoDepth    = 4,
  parameter bit          IgnoreAssert = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  axis_req_t        axis_in_req_i,
  output axis_rsp_t        axis_in_rsp_o,
  output narrow_req_flit_t narrow_req_o,
  input  narrow_req_flit_t narrow_req_i,
  output narrow_rsp_flit_t narrow_rsp_o,
  input  narrow_rsp_flit_t narrow_rsp_i,
  output wide_flit_t       wide_o,
  input  wide_flit_t       wide_i,
  output logic             idle_o,
  output logic [15:0]      drop_cnt_o,
  output logic [2:0]       credit_o,
  output rx_state_e        state_o
);

  rx_state_e state_q, state_d;

  logic [HdrWidth-1:0]         hdr;
  logic [WideFlitDataSize-1:0] flit_data;
  logic                        malformed;
  logic                        target_full;
  logic                        accept_en;
  logic                        tready;
  logic                        handshake;
  logic                        push_req, push_rsp, push_wide;
  logic                        drop;
  logic [15:0]                 drop_cnt_q;

  logic                          req_full, req_empty, req_valid, req_credit;
  logic                          rsp_full, rsp_empty, rsp_valid, rsp_credit;
  logic                          wide_full, wide_empty, wide_valid, wide_credit;
  logic [NarrowFlitDataSize-1:0] req_data, rsp_data;
  logic [WideFlitDataSize-1:0]   wide_data;

  assign hdr       = axis_in_req_i.t.data[HdrWidth-1:0];
  assign flit_data = axis_in_req_i.t.data[AxisDataWidth-1:HdrWidth];
  assign malformed = beat_malformed(hdr, axis_in_req_i.t.strb);

  always_comb begin
    target_full = 1'b1;
    case (hdr)
      narrow_request:  target_full = req_full;
      narrow_response: target_full = rsp_full;
      wide_channel:    target_full = wide_full;
      default:         target_full = 1'b1;
    endcase
  end

  // Dropping enable_i closes the input in the same cycle, before the FSM leaves ACTIVE.
  assign accept_en = (state_q == ACTIVE) && enable_i;
  assign tready    = accept_en && (malformed || !target_full);
  assign handshake = axis_in_req_i.tvalid && tready;

  assign push_req  = handshake && !malformed && (hdr == narrow_request);
  assign push_rsp  = handshake && !malformed && (hdr == narrow_response);
  assign push_wide = handshake && !malformed && (hdr == wide_channel);
  assign drop      = handshake && malformed;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DISABLED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DISABLED: if (enable_i) state_d = ACTIVE;
      ACTIVE:   if (!enable_i) state_d = DRAINING;
      DRAINING: begin
        if (enable_i) begin
          state_d = ACTIVE;
        end else if (req_empty && rsp_empty && wide_empty) begin
          state_d = DISABLED;
        end
      end
      default:  state_d = DISABLED;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  floo_axis_rx_chan_buf #(
    .Width(NarrowFlitDataSize), .Depth(FifoDepth), .IgnoreAssert(IgnoreAssert)
  ) i_req_buf (
    .clk_i, .rst_i,
    .push_i  (push_req),
    .data_i  (flit_data[NarrowFlitDataSize-1:0]),
    .full_o  (req_full),
    .empty_o (req_empty),
    .valid_o (req_valid),
    .ready_i (narrow_req_i.ready),
    .data_o  (req_data),
    .credit_o(req_credit)
  );

  floo_axis_rx_chan_buf #(
    .Width(NarrowFlitDataSize), .Depth(FifoDepth), .IgnoreAssert(IgnoreAssert)
  ) i_rsp_buf (
    .clk_i, .rst_i,
    .push_i  (push_rsp),
    .data_i  (flit_data[NarrowFlitDataSize-1:0]),
    .full_o  (rsp_full),
    .empty_o (rsp_empty),
    .valid_o (rsp_valid),
    .ready_i (narrow_rsp_i.ready),
    .data_o  (rsp_data),
    .credit_o(rsp_credit)
  );

  floo_axis_rx_chan_buf #(
    .Width(WideFlitDataSize), .Depth(FifoDepth), .IgnoreAssert(IgnoreAssert)
  ) i_wide_buf (
    .clk_i, .rst_i,
    .push_i  (push_wide),
    .data_i  (flit_data),
    .full_o  (wide_full),
    .empty_o (wide_empty),
    .valid_o (wide_valid),
    .ready_i (wide_i.ready),
    .data_o  (wide_data),
    .credit_o(wide_credit)
  );

  always_comb begin
    narrow_req_o       = '0;
    narrow_req_o.valid = req_valid;
    narrow_req_o.data  = req_data;
    narrow_rsp_o       = '0;
    narrow_rsp_o.valid = rsp_valid;
    narrow_rsp_o.data  = rsp_data;
    wide_o             = '0;
    wide_o.valid       = wide_valid;
    wide_o.data        = wide_data;
  end

  assign axis_in_rsp_o.tready = tready;
  assign idle_o               = (state_q == DISABLED);
  assign drop_cnt_o           = drop_cnt_q;
  assign credit_o             = {wide_credit, rsp_credit, req_credit};
  assign state_o              = state_q;

  // Inbound flit structs only carry a meaningful ready bit; the rest is ignored.
  logic unused_inputs;
  assign unused_inputs = ^{axis_in_req_i.t.last,
                           narrow_req_i.valid, narrow_req_i.data,
                           narrow_rsp_i.valid, narrow_rsp_i.data,
                           wide_i.valid, wide_i.data};

endmodule
